// File: rtl/bw_insn_window.sv
`default_nettype none
// ============================================================================
//  Module   : rfBlackWidowPkg / bw_insn_window
//  Purpose  : Instruction window queue between fetch and the BlackWidow
//             decoder. Fetched words are buffered in a circular queue. The
//             oldest word and the three words behind it are presented to
//             decode. The window is ready once the head instruction and its
//             whole constant-postfix group (CON1/CON2/CON3) are present. A
//             take retires the head together with its postfixes in one cycle.
//  Ports    : clk_i, rst_ni (sync, active low), flush_i
//             fetch_v_i / fetch_cnt_i / fetch_pc_i / fetch_ins_i -> push side
//             fetch_rdy_o : at least two free entries
//             ir_o..ir3_o, slot_v_o, pc_o, len_o, win_rdy_o   -> decode side
//             take_i      : decode accepts the head instruction
//  Revision : 1.0  initial release
// ============================================================================

package rfBlackWidowPkg;

    typedef struct packed {
        logic [32:0] payload;
        logic [6:0]  opcode;
    } AnyFmt;

    typedef union packed {
        AnyFmt       any;
        logic [39:0] raw;
    } Instruction;

    localparam logic [6:0] ADD  = 7'h02;
    localparam logic [6:0] ADDI = 7'h04;
    localparam logic [6:0] ORI  = 7'h0E;
    localparam logic [6:0] LDO  = 7'h46;
    localparam logic [6:0] CON1 = 7'h50;
    localparam logic [6:0] CON2 = 7'h51;
    localparam logic [6:0] CON3 = 7'h52;

endpackage

module bw_insn_window
    import rfBlackWidowPkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ISTEP = 5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        fetch_v_i,
    input  logic [1:0]  fetch_cnt_i,
    input  logic [63:0] fetch_pc_i,
    input  Instruction  fetch_ins_i [0:1],
    output logic        fetch_rdy_o,
    output Instruction  ir_o,
    output Instruction  ir1_o,
    output Instruction  ir2_o,
    output Instruction  ir3_o,
    output logic [3:0]  slot_v_o,
    output logic [63:0] pc_o,
    output logic [2:0]  len_o,
    output logic        win_rdy_o,
    input  logic        take_i
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_PUSH_LIMIT = c_CNT_W'(DEPTH - 2);
    localparam logic [63:0]        c_ISTEP      = 64'(ISTEP);

    // Queue storage; contents are never cleared, validity comes from r_count.
    Instruction         r_word [DEPTH];
    logic [63:0]        r_pc   [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    Instruction         w_slot   [4];
    logic [c_PTR_W-1:0] w_idx    [4];
    logic [3:0]         w_slot_v;
    logic [3:1]         w_is_con;
    logic [1:0]         w_pfx;
    logic [2:0]         w_len;
    logic               w_win_rdy;
    logic               w_fetch_rdy;
    logic               w_push;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_push_n;
    logic [c_CNT_W-1:0] w_pop_n;

    // Window slots: pointer arithmetic wraps naturally at c_PTR_W bits, so
    // a group straddling the last entry needs no special handling.
    genvar k;
    for (k = 0; k < 4; k++) begin : g_slot
        assign w_idx[k]    = r_head + c_PTR_W'(k);
        assign w_slot_v[k] = (r_count > c_CNT_W'(k));
        // Invalid slots read as zero so they can never look like a CON word.
        assign w_slot[k]   = w_slot_v[k] ? r_word[w_idx[k]] : '0;
        if (k > 0) begin : g_con
            assign w_is_con[k] = (w_slot[k].any.opcode == CON1) ||
                                 (w_slot[k].any.opcode == CON2) ||
                                 (w_slot[k].any.opcode == CON3);
        end
    end

    // Postfix count: run of consecutive CON words starting at slot 1.
    always_comb begin
        w_pfx = 2'd0;
        if (w_is_con[1]) begin
            w_pfx = 2'd1;
            if (w_is_con[2]) begin
                w_pfx = 2'd2;
                if (w_is_con[3]) begin
                    w_pfx = 2'd3;
                end
            end
        end
    end

    assign w_len = {1'b0, w_pfx} + 3'd1;

    // Ready needs either a visible non-CON terminator behind the group or a
    // group at its maximum size, otherwise more postfixes may still arrive.
    assign w_win_rdy   = w_slot_v[0] &&
                         ((w_pfx == 2'd3) ||
                          (r_count >= (c_CNT_W'(w_pfx) + c_CNT_W'(2))));
    assign w_fetch_rdy = (r_count <= c_PUSH_LIMIT);

    // Free-space check uses the pre-pop count; reset and flush kill both.
    assign w_push   = rst_ni && !flush_i && fetch_v_i && w_fetch_rdy;
    assign w_pop    = rst_ni && !flush_i && take_i && w_win_rdy;
    assign w_push_n = w_push ? ((fetch_cnt_i == 2'd2) ? c_CNT_W'(2) : c_CNT_W'(1))
                             : '0;
    assign w_pop_n  = w_pop ? c_CNT_W'(w_len) : '0;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_word[r_tail] <= fetch_ins_i[0];
            r_pc[r_tail]   <= fetch_pc_i;
            if (fetch_cnt_i == 2'd2) begin
                r_word[r_tail + c_PTR_W'(1)] <= fetch_ins_i[1];
                r_pc[r_tail + c_PTR_W'(1)]   <= fetch_pc_i + c_ISTEP;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + w_push_n[c_PTR_W-1:0];
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(w_len);
            end
            r_count <= r_count + w_push_n - w_pop_n;
        end
    end

    assign ir_o        = w_slot[0];
    assign ir1_o       = w_slot[1];
    assign ir2_o       = w_slot[2];
    assign ir3_o       = w_slot[3];
    assign slot_v_o    = w_slot_v;
    assign pc_o        = w_slot_v[0] ? r_pc[r_head] : '0;
    assign len_o       = w_len;
    assign win_rdy_o   = w_win_rdy;
    assign fetch_rdy_o = w_fetch_rdy;

endmodule

`default_nettype wire
